// File: rtl/tinyriscv_pkg.sv
// tinyriscv_pkg: shared widths and pipeline-control state encoding
package tinyriscv_pkg;
  localparam int INST_ADDR_BUS = 32;
  localparam int PIPE_NUM_STAGES = 5;
  typedef enum logic [1:0] {PC_IDLE, PC_FLUSH, PC_STALL} pipe_ctrl_state_e;
endpackage

// File: rtl/pipe_ctrl_unit_hold_encoder.sv
// pipe_hold_encoder: expands raw stage holds upstream from the highest held stage and places one bubble below it
module pipe_hold_encoder #(
  parameter int NUM_STAGES = 5
) (
  input  logic [NUM_STAGES-1:0] raw,
  output logic [NUM_STAGES-1:0] hold,
  output logic [NUM_STAGES-1:0] bubble
);
  assign bubble[0] = 1'b0;
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_hold
    assign hold[i] = |raw[NUM_STAGES-1:i];
    if (i > 0) begin : g_bub
      assign bubble[i] = hold[i-1] & ~hold[i];
    end
  end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipeline hold/flush controller with flush FSM and stall timeout (PIPE_CTRL_PERF_EN adds perf counters)
module pipe_ctrl_unit
  import tinyriscv_pkg::*;
#(
  parameter int NUM_STAGES = PIPE_NUM_STAGES,
  parameter int NUM_REQ = 3,
  parameter logic [NUM_REQ*NUM_STAGES-1:0] HOLD_MASK = '1,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump_req_i,
  input  logic [INST_ADDR_BUS-1:0] jump_addr_i,
  input  logic [NUM_REQ-1:0]       clear_req_i,
  input  logic [NUM_REQ-1:0]       hold_req_i,
  output logic                     jump_flag_o,
  output logic [INST_ADDR_BUS-1:0] jump_addr_o,
  output logic [NUM_STAGES-1:0]    stage_hold_o,
  output logic [NUM_STAGES-1:0]    stage_flush_o,
  output logic                     busy_o,
  output logic                     stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]              perf_flush_cnt_o,
  output logic [31:0]              perf_stall_cyc_o
`endif
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam int TW = $clog2(STALL_TIMEOUT + 1);
  pipe_ctrl_state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [NUM_STAGES-1:0] raw, enc_hold, enc_bubble;
  logic jc, flushing;
  assign jc = jump_req_i | (|clear_req_i);
  always_comb begin
    raw = '0;
    for (int r = 0; r < NUM_REQ; r++)
      for (int s = 0; s < NUM_STAGES; s++)
        raw[s] = raw[s] | (hold_req_i[r] & HOLD_MASK[r*NUM_STAGES+s]);
  end
  pipe_hold_encoder #(.NUM_STAGES(NUM_STAGES)) u_enc (
    .raw(raw),
    .hold(enc_hold),
    .bubble(enc_bubble)
  );
  always_comb begin
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    stage_hold_o = '0;
    stage_flush_o = '0;
    cnt_nx = cnt;
    if (jc) begin
      jump_flag_o = jump_req_i;
      jump_addr_o = jump_req_i ? jump_addr_i : '0;
      stage_flush_o = '1;
      cnt_nx = CW'(FLUSH_CYCLES - 1);
    end else if (state == PC_FLUSH) begin
      stage_flush_o = '1;
      cnt_nx = cnt - 1'b1;
    end else begin
      stage_hold_o = enc_hold;
      stage_flush_o = enc_bubble;
    end
    flushing = jc || state == PC_FLUSH;
    state_nx = (flushing && cnt_nx != '0) ? PC_FLUSH : (|hold_req_i) ? PC_STALL : PC_IDLE;
    tcnt_nx = (state_nx == PC_STALL && !jc) ? ((tcnt == TW'(STALL_TIMEOUT)) ? tcnt : tcnt + 1'b1) : '0;
    if (rst) begin
      jump_flag_o = 1'b0;
      jump_addr_o = '0;
      stage_hold_o = '0;
      stage_flush_o = '0;
    end
  end
  assign busy_o = !rst && state != PC_IDLE;
  assign stall_timeout_o = !rst && tcnt == TW'(STALL_TIMEOUT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PC_IDLE;
      cnt <= '0;
      tcnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      tcnt <= tcnt_nx;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pf, ps;
  always_ff @(posedge clk) begin
    if (rst) begin
      pf <= '0;
      ps <= '0;
    end else begin
      pf <= jc ? pf + 1 : pf;
      ps <= (state == PC_STALL) ? ps + 1 : ps;
    end
  end
  assign perf_flush_cnt_o = rst ? '0 : pf;
  assign perf_stall_cyc_o = rst ? '0 : ps;
`endif
endmodule
